// File: rtl/vga_seq_pkg.sv
// Shared types and constants for the VGA console write sequencer.
package vga_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  localparam logic [1:0]  HTRANS_IDLE      = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ    = 2'b10;
  localparam logic [31:0] VGA_BASE_DEFAULT = 32'h5000_0000;

endpackage

// File: rtl/vga_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie
// and moves to the loser after every grant.
module vga_rr_arb2
  import vga_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       enable,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       grant_id
);

  logic ptr_r;

  // Grant selection: a lone requester wins, a tie goes to the pointer
  always_comb begin
    grant    = 2'b00;
    grant_id = 1'b0;
    if (enable) begin
      case (valid)
        2'b01:   begin grant = 2'b01; grant_id = 1'b0; end
        2'b10:   begin grant = 2'b10; grant_id = 1'b1; end
        2'b11:   begin grant = ptr_r ? 2'b10 : 2'b01; grant_id = ptr_r; end
        default: begin grant = 2'b00; grant_id = 1'b0; end
      endcase
    end else begin
      grant    = 2'b00;
      grant_id = 1'b0;
    end
  end

  // Pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= 1'b0;
    end else if (advance && (grant != 2'b00)) begin
      ptr_r <= ~grant_id;
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/vga_console_seq.sv
// Two-client console write sequencer issuing single AHB-Lite NONSEQ writes.
// Optional stall abort enabled by defining VGA_SEQ_TIMEOUT_EN.
module vga_console_seq
  import vga_seq_pkg::*;
#(
  parameter logic [31:0] VGA_BASE       = VGA_BASE_DEFAULT,
  parameter int          DATA_W         = 8,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              HSEL,
  output logic [31:0]       HADDR,
  output logic [1:0]        HTRANS,
  output logic              HWRITE,
  output logic [31:0]       HWDATA,
  input  logic              HREADY,
  input  logic              dls_error,
  output logic              grant_id,
  output logic              busy,
  output logic              halted,
  output logic              timeout_err
);

  state_e            state_r, next_s;
  logic [DATA_W-1:0] char_r;
  logic [DATA_W-1:0] win_data_s;
  logic [1:0]        grant_s;
  logic              grant_id_s;
  logic              enable_s;
  logic              abort_s;
  logic              hsel_r, hwrite_r, busy_r, halted_r, grant_id_r, timeout_r;
  logic [1:0]        htrans_r;
  logic [31:0]       haddr_r, hwdata_r;

  assign enable_s = !halted_r && ((state_r == IDLE) || ((state_r == DATA) && HREADY));

  vga_rr_arb2 u_arb (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .valid    ({req1_valid, req0_valid}),
    .enable   (enable_s),
    .advance  (grant_s != 2'b00),
    .grant    (grant_s),
    .grant_id (grant_id_s)
  );

  // Readys are gated by reset so every output is low while HRESETn is held
  assign req0_ready = grant_s[0] & HRESETn;
  assign req1_ready = grant_s[1] & HRESETn;
  assign win_data_s = grant_id_s ? req1_data : req0_data;

`ifdef VGA_SEQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] stall_cnt_r;
  logic             stall_s;

  assign stall_s = (state_r != IDLE) && !HREADY;
  assign abort_s = stall_s && (stall_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

  // Consecutive stall counter, cleared by any HREADY or abort
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      stall_cnt_r <= '0;
    end else if (abort_s || !stall_s) begin
      stall_cnt_r <= '0;
    end else begin
      stall_cnt_r <= stall_cnt_r + 1'b1;
    end
  end
`else
  assign abort_s = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_s != 2'b00) next_s = ADDR;
        else                  next_s = IDLE;
      end
      ADDR: begin
        if (abort_s)     next_s = IDLE;
        else if (HREADY) next_s = DATA;
        else             next_s = ADDR;
      end
      DATA: begin
        if (abort_s)                   next_s = IDLE;
        else if (!HREADY)              next_s = DATA;
        else if (grant_s != 2'b00)     next_s = ADDR;
        else                           next_s = IDLE;
      end
      default: next_s = IDLE;
    endcase
  end

  // State, latched character and registered bus/status outputs
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r    <= IDLE;
      char_r     <= '0;
      hsel_r     <= 1'b0;
      hwrite_r   <= 1'b0;
      htrans_r   <= HTRANS_IDLE;
      haddr_r    <= 32'h0;
      hwdata_r   <= 32'h0;
      busy_r     <= 1'b0;
      halted_r   <= 1'b0;
      grant_id_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      state_r   <= next_s;
      hsel_r    <= (next_s == ADDR);
      hwrite_r  <= (next_s == ADDR);
      htrans_r  <= (next_s == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
      haddr_r   <= (next_s == ADDR) ? VGA_BASE : 32'h0;
      busy_r    <= (next_s != IDLE);
      halted_r  <= halted_r | dls_error;
      timeout_r <= abort_s;
      // HWDATA only changes when an address phase completes
      if ((state_r == ADDR) && (next_s == DATA)) begin
        hwdata_r <= {{(32-DATA_W){1'b0}}, char_r};
      end else begin
        hwdata_r <= hwdata_r;
      end
      if (grant_s != 2'b00) begin
        char_r     <= win_data_s;
        grant_id_r <= grant_id_s;
      end else begin
        char_r     <= char_r;
        grant_id_r <= grant_id_r;
      end
    end
  end

  assign HSEL        = hsel_r;
  assign HADDR       = haddr_r;
  assign HTRANS      = htrans_r;
  assign HWRITE      = hwrite_r;
  assign HWDATA      = hwdata_r;
  assign grant_id    = grant_id_r;
  assign busy        = busy_r;
  assign halted      = halted_r;
  assign timeout_err = timeout_r;

endmodule

// File: tb/tb_vga_console_seq.sv
// Bench for vga_console_seq: per-cycle behavioural model plus directed checks.
module tb_vga_console_seq;

  localparam logic [31:0] BASE = 32'h5000_0000;
  localparam int          TO_N = 8;
`ifdef VGA_SEQ_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [7:0]  req0_data = 8'h00, req1_data = 8'h00;
  logic        req0_ready, req1_ready;
  logic        HSEL, HWRITE, HREADY = 1'b1, dls_error = 1'b0;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        grant_id, busy, halted, timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 HCLK = ~HCLK;

  vga_console_seq #(.TIMEOUT_CYCLES(TO_N)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(HREADY), .dls_error(dls_error), .grant_id(grant_id), .busy(busy),
    .halted(halted), .timeout_err(timeout_err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: phase 0 = no transfer, 1 = address phase, 2 = data phase
  int          m_phase = 0, m_ptr = 0, m_id = 0, m_stall = 0;
  logic [7:0]  m_char = 8'h00;
  logic [31:0] m_hwdata = 32'h0;
  bit          m_halted = 1'b0, m_to = 1'b0;

  function automatic int win();
    if (m_halted || !(m_phase == 0 || (m_phase == 2 && HREADY))) return -1;
    if (req0_valid && req1_valid) return m_ptr;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m_phase <= 0; m_ptr <= 0; m_id <= 0; m_stall <= 0;
      m_char <= 8'h00; m_hwdata <= 32'h0; m_halted <= 1'b0; m_to <= 1'b0;
    end else begin
      m_halted <= m_halted | dls_error;
      if (TO_EN && m_phase != 0 && !HREADY && (m_stall + 1 == TO_N)) begin
        m_phase <= 0; m_to <= 1'b1; m_stall <= 0;
      end else begin
        m_to    <= 1'b0;
        m_stall <= (m_phase != 0 && !HREADY) ? m_stall + 1 : 0;
        if (m_phase == 0 && win() >= 0) m_phase <= 1;
        else if (m_phase == 1 && HREADY) begin
          m_phase  <= 2;
          m_hwdata <= {24'h0, m_char};
        end else if (m_phase == 2 && HREADY) m_phase <= (win() >= 0) ? 1 : 0;
        if (win() >= 0) begin
          m_char <= (win() == 1) ? req1_data : req0_data;
          m_id   <= win();
          m_ptr  <= 1 - win();
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model
  always @(negedge HCLK) begin
    if (HRESETn) begin
      chk("m_hsel",    HSEL,        m_phase == 1);
      chk("m_hwrite",  HWRITE,      m_phase == 1);
      chk("m_htrans",  HTRANS,      (m_phase == 1) ? 2'b10 : 2'b00);
      chk("m_haddr",   HADDR,       (m_phase == 1) ? BASE : 32'h0);
      chk("m_hwdata",  HWDATA,      m_hwdata);
      chk("m_busy",    busy,        m_phase != 0);
      chk("m_gid",     grant_id,    m_id);
      chk("m_halted",  halted,      m_halted);
      chk("m_timeout", timeout_err, m_to);
      chk("m_ready0",  req0_ready,  win() == 0);
      chk("m_ready1",  req1_ready,  win() == 1);
    end
  end

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  int   gq[$];
  logic [1:0] ht [8];

  initial begin
    #1 HRESETn = 1'b0;
    repeat (2) tick();
    chk("rst_hsel", HSEL, 1'b0);     chk("rst_htrans", HTRANS, 2'b00);
    chk("rst_haddr", HADDR, 32'h0);  chk("rst_hwdata", HWDATA, 32'h0);
    chk("rst_busy", busy, 1'b0);     chk("rst_halted", halted, 1'b0);
    HRESETn = 1'b1;
    tick();

    // Single write, zero-wait slave
    req0_valid = 1'b1; req0_data = 8'h41;
    @(negedge HCLK); chk("t1_ready0", req0_ready, 1'b1); chk("t1_ready1", req1_ready, 1'b0);
    tick(); req0_valid = 1'b0;
    @(negedge HCLK); chk("t1_htrans", HTRANS, 2'b10); chk("t1_haddr", HADDR, 32'h5000_0000);
    tick();
    @(negedge HCLK); chk("t1_hwdata", HWDATA, 32'h0000_0041); chk("t1_dtrans", HTRANS, 2'b00);
    tick();
    @(negedge HCLK); chk("t1_idle", busy, 1'b0);
    tick();

    HRESETn = 1'b0; tick(); HRESETn = 1'b1; tick();

    // Both clients held: alternating back-to-back grants
    req0_valid = 1'b1; req0_data = 8'h41; req1_valid = 1'b1; req1_data = 8'h42;
    for (int i = 0; i < 8; i++) begin
      @(negedge HCLK);
      if (req0_ready) gq.push_back(0);
      if (req1_ready) gq.push_back(1);
      ht[i] = HTRANS;
      tick();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t2_count", gq.size(), 4);
    for (int k = 0; k < 4; k++) chk("t2_order", (k < gq.size()) ? gq[k] : 9, k % 2);
    for (int i = 1; i < 8; i++) chk("t2_htrans", ht[i], (i % 2 == 1) ? 2'b10 : 2'b00);
    repeat (2) tick();

    // Data-phase wait states
    req0_valid = 1'b1; req0_data = 8'h43;
    @(negedge HCLK); chk("t3_ready0", req0_ready, 1'b1);
    tick(); req0_valid = 1'b0;
    tick(); HREADY = 1'b0; req1_valid = 1'b1; req1_data = 8'h44;
    for (int k = 0; k < 3; k++) begin
      @(negedge HCLK);
      chk("t3_hwdata", HWDATA, 32'h43);
      chk("t3_rdy0", req0_ready, 1'b0); chk("t3_rdy1", req1_ready, 1'b0);
      tick();
    end
    HREADY = 1'b1;
    @(negedge HCLK); chk("t3_hwdata4", HWDATA, 32'h43); chk("t3_b2b", req1_ready, 1'b1);
    tick(); req1_valid = 1'b0;
    repeat (3) tick();

    // Long address-phase stall
    req0_valid = 1'b1; req0_data = 8'h46;
    @(negedge HCLK); chk("t6_ready0", req0_ready, 1'b1);
    tick(); req0_valid = 1'b0; HREADY = 1'b0;
`ifdef VGA_SEQ_TIMEOUT_EN
    for (int k = 0; k < TO_N; k++) begin
      @(negedge HCLK); chk("t6_noto", timeout_err, 1'b0); chk("t6_busy", busy, 1'b1);
      tick();
    end
    @(negedge HCLK); chk("t6_pulse", timeout_err, 1'b1); chk("t6_idle", busy, 1'b0);
    chk("t6_hsel", HSEL, 1'b0);
    tick(); HREADY = 1'b1; req0_valid = 1'b1; req0_data = 8'h47;
    @(negedge HCLK); chk("t6_once", timeout_err, 1'b0); chk("t6_next", req0_ready, 1'b1);
    tick(); req0_valid = 1'b0;
    repeat (3) tick();
`else
    for (int k = 0; k < 12; k++) begin
      @(negedge HCLK); chk("t6_noto", timeout_err, 1'b0); chk("t6_hold", HTRANS, 2'b10);
      tick();
    end
    HREADY = 1'b1;
    repeat (4) tick();
`endif

    // Asynchronous reset during the address phase
    req0_valid = 1'b1; req0_data = 8'h48;
    @(negedge HCLK); chk("t5_ready0", req0_ready, 1'b1);
    tick(); req0_valid = 1'b0;
    @(negedge HCLK); chk("t5_addr", HSEL, 1'b1);
    #2 HRESETn = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("t5_hsel", HSEL, 1'b0);     chk("t5_htrans", HTRANS, 2'b00);
    chk("t5_haddr", HADDR, 32'h0);  chk("t5_hwrite", HWRITE, 1'b0);
    chk("t5_hwdata", HWDATA, 32'h0); chk("t5_busy", busy, 1'b0);
    chk("t5_rdy0", req0_ready, 1'b0); chk("t5_rdy1", req1_ready, 1'b0);
    @(posedge HCLK); #1; HRESETn = 1'b1;
    @(negedge HCLK); chk("t5_first0", req0_ready, 1'b1); chk("t5_first1", req1_ready, 1'b0);
    tick(); req0_valid = 1'b0; req1_valid = 1'b0;
    repeat (3) tick();

    // Lockstep fault during the data phase
    req0_valid = 1'b1; req0_data = 8'h45;
    @(negedge HCLK); chk("t4_ready0", req0_ready, 1'b1);
    tick(); req0_valid = 1'b0;
    tick(); dls_error = 1'b1;
    @(negedge HCLK); chk("t4_nothalt", halted, 1'b0); chk("t4_busy", busy, 1'b1);
    tick(); dls_error = 1'b0;
    @(negedge HCLK); chk("t4_halted", halted, 1'b1); chk("t4_done", busy, 1'b0);
    chk("t4_hwdata", HWDATA, 32'h45);
    tick(); req0_valid = 1'b1; req0_data = 8'h49;
    for (int k = 0; k < 20; k++) begin
      @(negedge HCLK); chk("t4_noready", req0_ready, 1'b0);
      tick();
    end
    req0_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d failures %0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule
